// File: rtl/scmp_bus_responder.sv
// SC/MP external-bus responder: latches the multiplexed address/flags and serves accesses from
// internal RAM or a one-page I/O port. Write protection: define SCMP_BUS_RESP_WRPROT_EN.
module scmp_bus_responder #(
  parameter int unsigned MEM_AW  = 12,
  parameter logic [7:0]  IO_PAGE = 8'hFF,
  parameter logic [15:0] WP_TOP  = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ads_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [11:0] addr,
  input  logic [7:0]  d_i,
  output logic [7:0]  d_o,
  output logic        d_oe,
  output logic [7:0]  io_addr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  output logic [3:0]  cyc_flags,
  output logic        halt_o,
`ifdef SCMP_BUS_RESP_WRPROT_EN
  output logic        wp_viol_o,
`endif
  output logic        err_o
);

`ifdef SCMP_BUS_RESP_WRPROT_EN
  localparam bit WpEn = 1'b1;
`else
  localparam bit WpEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StAddr, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic [15:0]       addr_q, addr_d, new_addr;
  logic [3:0]        flags_q, flags_d;
  logic [7:0]        wdata_q, wdata_d, rdata_q;
  logic              halt_q, halt_d;
  logic              err_q, err_d;
  logic              first_q, first_d;
  logic              do_latch;
  logic              io_sel, commit, wp_hit, ram_we, bypass;
  logic [MEM_AW-1:0] rd_idx, wr_idx;
  logic [7:0]        mem [2**MEM_AW];

  assign new_addr = {d_i[3:0], addr};
  assign rd_idx   = new_addr[MEM_AW-1:0];
  assign wr_idx   = addr_q[MEM_AW-1:0];
  assign io_sel   = (addr_q[15:8] == IO_PAGE);
  // Commit is the first wr_n-high cycle in WRITE; a reset in that cycle cancels it.
  assign commit   = (state_q == StWrite) && wr_n && !rst;
  assign wp_hit   = WpEn && !io_sel && (addr_q < WP_TOP);
  assign ram_we   = commit && !io_sel && !wp_hit;
  // A read latched on the commit edge of the same byte must see the new data.
  assign bypass   = ram_we && (wr_idx == rd_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      flags_q <= '0;
      wdata_q <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      flags_q <= flags_d;
      wdata_q <= wdata_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    flags_d  = flags_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    first_d  = 1'b0;
    do_latch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!ads_n)             do_latch = 1'b1;
        else if (!rd_n || !wr_n) err_d   = 1'b1;
      end
      StAddr: begin
        if (!ads_n) begin
          do_latch = 1'b1;
        end else if (!rd_n && !wr_n) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (!rd_n) begin
          state_d = StRead;
          first_d = 1'b1;
        end else if (!wr_n) begin
          state_d = StWrite;
          wdata_d = d_i;
        end
      end
      StRead: begin
        if (!ads_n)    do_latch = 1'b1;
        else if (rd_n) state_d  = StIdle;
      end
      StWrite: begin
        if (!wr_n) begin
          if (!ads_n) begin
            err_d    = 1'b1;
            do_latch = 1'b1;
          end else begin
            wdata_d = d_i;
          end
        end else if (!ads_n) begin
          do_latch = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (do_latch) begin
      state_d = StAddr;
      addr_d  = new_addr;
      flags_d = d_i[7:4];
    end
    halt_d = do_latch && d_i[7];
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_idx] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst)           rdata_q <= '0;
    else if (do_latch) rdata_q <= bypass ? wdata_q : mem[rd_idx];
  end

`ifdef SCMP_BUS_RESP_WRPROT_EN
  logic wp_viol_q;
  always_ff @(posedge clk) begin
    if (rst)                    wp_viol_q <= 1'b0;
    else if (commit && wp_hit)  wp_viol_q <= 1'b1;
  end
  assign wp_viol_o = wp_viol_q;
`endif

  always_comb begin
    d_oe = (state_q == StRead) && !rd_n && ads_n && wr_n;
    d_o  = '0;
    if (d_oe) d_o = io_sel ? io_rdata : rdata_q;
    io_rd     = (state_q == StRead) && first_q && io_sel && !rst;
    io_wr     = commit && io_sel;
    io_wdata  = wdata_q;
    io_addr   = addr_q[7:0];
    cyc_flags = flags_q;
    halt_o    = halt_q;
    err_o     = err_q;
  end

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Randomized scoreboard bench for scmp_bus_responder: bus-cycle tasks push expected output
// events, a negedge monitor pops and compares them whenever the DUT drives a strobe.
module tb_scmp_bus_responder;

`ifdef SCMP_BUS_RESP_WRPROT_EN
  localparam bit WpOn = 1'b1;
`else
  localparam bit WpOn = 1'b0;
`endif

  typedef struct packed {
    logic       d_oe;
    logic [7:0] d_o;
    logic       io_rd;
    logic       io_wr;
    logic [7:0] io_wdata;
    logic [7:0] io_addr;
    logic       halt;
    logic [3:0] flags;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ads_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [11:0] addr = '0;
  logic [7:0]  d_i = '0;
  logic [7:0]  d_o, io_addr, io_wdata, io_rdata;
  logic        d_oe, io_rd, io_wr, halt_o, err_o;
  logic [3:0]  cyc_flags;
`ifdef SCMP_BUS_RESP_WRPROT_EN
  logic        wp_viol_o;
`endif

  logic [7:0]  periph [256];
  logic [7:0]  io_m   [256];
  logic [7:0]  ram_m  [4096];
  logic [11:0] wr_list [$];
  ev_t         exp_q [$];
  ev_t         mon_e;
  int          n_checks = 0;
  int          n_errors = 0;

  scmp_bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .ads_n     (ads_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .addr      (addr),
    .d_i       (d_i),
    .d_o       (d_o),
    .d_oe      (d_oe),
    .io_addr   (io_addr),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .cyc_flags (cyc_flags),
    .halt_o    (halt_o),
`ifdef SCMP_BUS_RESP_WRPROT_EN
    .wp_viol_o (wp_viol_o),
`endif
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // Peripheral: a 256-byte register file with a known pattern after reset.
  assign io_rdata = periph[io_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) periph[i] <= 8'(i) ^ 8'h67;
    end else if (io_wr) begin
      periph[io_addr] <= io_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (d_oe || io_rd || io_wr || halt_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {28'h0, d_oe, io_rd, io_wr, halt_o}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("bus_event",
              {d_oe, io_rd, io_wr, halt_o, cyc_flags, io_addr,
               mon_e.d_oe ? d_o : 8'h00, mon_e.io_wr ? io_wdata : 8'h00},
              {mon_e.d_oe, mon_e.io_rd, mon_e.io_wr, mon_e.halt, mon_e.flags, mon_e.io_addr,
               mon_e.d_o, mon_e.io_wdata});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ev_t ev_base(input logic [15:0] a, input logic [3:0] f);
    ev_t e;
    e         = '0;
    e.io_addr = a[7:0];
    e.flags   = f;
    return e;
  endfunction

  function automatic bit is_io(input logic [15:0] a);
    return a[15:8] == 8'hFF;
  endfunction

  function automatic bit wp_block(input logic [15:0] a);
    return WpOn && !is_io(a) && (a < 16'h0400);
  endfunction

  // One bus slot: inputs held from just after one rising edge until the next.
  task automatic slot(input logic a_n, input logic r_n, input logic w_n,
                      input logic [11:0] ad, input logic [7:0] d);
    ads_n = a_n; rd_n = r_n; wr_n = w_n; addr = ad; d_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    slot(1'b1, 1'b1, 1'b1, 12'h000, 8'h00);
    slot(1'b1, 1'b1, 1'b1, 12'h000, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) io_m[i] = 8'(i) ^ 8'h67;
  endtask

  task automatic ads(input logic [15:0] a, input logic [3:0] f);
    slot(1'b0, 1'b1, 1'b1, a[11:0], {f, a[15:12]});
  endtask

  // chain=1 leaves the commit slot to the next transaction's address strobe.
  task automatic bus_write(input logic [15:0] a, input logic [3:0] f, input logic [7:0] data,
                           input bit chain);
    ev_t e;
    ads(a, f);
    if (f[3]) begin
      e = ev_base(a, f); e.halt = 1'b1; exp_q.push_back(e);
    end
    slot(1'b1, 1'b1, 1'b0, a[11:0], data);
    if (is_io(a)) begin
      io_m[a[7:0]] = data;
      e = ev_base(a, f); e.io_wr = 1'b1; e.io_wdata = data; exp_q.push_back(e);
    end else if (!wp_block(a)) begin
      ram_m[a[11:0]] = data;
      wr_list.push_back(a[11:0]);
    end
    if (!chain) slot(1'b1, 1'b1, 1'b1, a[11:0], 8'h00);
  endtask

  task automatic read_tail(input logic [15:0] a, input logic [3:0] f, input int nrd);
    ev_t        e;
    logic [7:0] exp_d;
    exp_d = is_io(a) ? io_m[a[7:0]] : ram_m[a[11:0]];
    if (f[3]) begin
      e = ev_base(a, f); e.halt = 1'b1; exp_q.push_back(e);
    end
    slot(1'b1, 1'b0, 1'b1, a[11:0], 8'h00);
    for (int i = 0; i < nrd - 1; i++) begin
      e = ev_base(a, f);
      e.d_oe  = 1'b1;
      e.d_o   = exp_d;
      e.io_rd = is_io(a) && (i == 0);
      exp_q.push_back(e);
      slot(1'b1, 1'b0, 1'b1, a[11:0], 8'h00);
    end
    slot(1'b1, 1'b1, 1'b1, a[11:0], 8'h00);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [3:0] f, input int nrd);
    ads(a, f);
    read_tail(a, f, nrd);
  endtask

  initial begin
    logic [15:0] a;
    logic [11:0] idx;
    int          kind;
    bit          chain;

    do_reset();
    check("rst_d_o", d_o, 0);
    check("rst_d_oe", d_oe, 0);
    check("rst_io_rd", io_rd, 0);
    check("rst_io_wr", io_wr, 0);
    check("rst_io_wdata", io_wdata, 0);
    check("rst_io_addr", io_addr, 0);
    check("rst_cyc_flags", cyc_flags, 0);
    check("rst_halt", halt_o, 0);
    check("rst_err", err_o, 0);

    // RAM[0x123] seeded through an alias above the protected range.
    bus_write(16'h1123, 4'h0, 8'h11, 1'b0);
    ads(16'h0123, 4'h0);
    slot(1'b1, 1'b1, 1'b0, 12'h123, 8'h5A);
    do_reset();
    check("midrst_io_wdata", io_wdata, 0);
    check("midrst_io_addr", io_addr, 0);
    check("midrst_d_oe", d_oe, 0);
    check("midrst_err", err_o, 0);
    bus_read(16'h0123, 4'h0, 2);

    bus_write(16'h1234, 4'h0, 8'hC3, 1'b0);
    bus_read(16'h1234, 4'h0, 2);
    bus_read(16'hFF10, 4'h0, 3);
    bus_write(16'hFF20, 4'h8, 8'h3C, 1'b0);
    bus_read(16'hFF20, 4'h0, 2);
    bus_write(16'h0456, 4'h0, 8'hAA, 1'b1);
    bus_read(16'h0456, 4'h0, 2);
    bus_write(16'hFF33, 4'h2, 8'h5E, 1'b1);
    bus_read(16'hFF33, 4'h0, 2);

    for (int t = 0; t < 300; t++) begin
      kind  = $urandom_range(0, 3);
      chain = ($urandom_range(0, 1) == 1) && (t < 299);
      if (kind == 2 && wr_list.size() == 0) kind = 0;
      case (kind)
        0: begin
          a = 16'($urandom);
          if (is_io(a)) a[15] = 1'b0;
          bus_write(a, 4'($urandom), 8'($urandom), chain);
        end
        1: bus_write({8'hFF, 8'($urandom)}, 4'($urandom), 8'($urandom), chain);
        2: begin
          idx = wr_list[$urandom_range(0, wr_list.size() - 1)];
          a   = {4'($urandom), idx};
          if (is_io(a)) a[15:12] = 4'h0;
          bus_read(a, 4'($urandom), $urandom_range(2, 4));
        end
        default: bus_read({8'hFF, 8'($urandom)}, 4'($urandom), $urandom_range(2, 4));
      endcase
    end
    slot(1'b1, 1'b1, 1'b1, 12'h000, 8'h00);
    check("no_err_after_random", err_o, 0);

`ifdef SCMP_BUS_RESP_WRPROT_EN
    do_reset();
    check("wp_rst", wp_viol_o, 0);
    bus_write(16'h1010, 4'h0, 8'h55, 1'b0);
    check("wp_clear_after_ok_write", wp_viol_o, 0);
    bus_write(16'h0010, 4'h0, 8'hAA, 1'b0);
    check("wp_set", wp_viol_o, 1);
    bus_read(16'h0010, 4'h0, 2);
    bus_write(16'h0400, 4'h0, 8'h66, 1'b0);
    bus_read(16'h0400, 4'h0, 2);
`endif

    // rd_n and wr_n low together after an address.
    ads(16'h0100, 4'h0);
    slot(1'b1, 1'b0, 1'b0, 12'h100, 8'h00);
    slot(1'b1, 1'b1, 1'b1, 12'h100, 8'h00);
    check("err_rdwr", err_o, 1);
    for (int i = 0; i < 3; i++) slot(1'b1, 1'b1, 1'b1, 12'h000, 8'h00);
    check("err_sticky", err_o, 1);
    do_reset();
    check("err_cleared", err_o, 0);

    // Read strobe with no prior address.
    ads_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
    #3;
    check("idle_rd_doe", d_oe, 0);
    @(posedge clk);
    #1;
    rd_n = 1'b1;
    check("err_idle_rd", err_o, 1);
    do_reset();

    // Address strobe during an open write drops the write.
    ads(16'h0123, 4'h0);
    slot(1'b1, 1'b1, 1'b0, 12'h123, 8'h99);
    slot(1'b0, 1'b1, 1'b0, 12'h123, 8'h00);
    check("err_ads_in_write", err_o, 1);
    read_tail(16'h0123, 4'h0, 2);

    for (int i = 0; i < 4; i++) slot(1'b1, 1'b1, 1'b1, 12'h000, 8'h00);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/scmp_bus_responder.md
Name: scmp_bus_responder

Overview:
Bus-side responder for the SC/MP core's multiplexed external bus. It sits on the pins the core drives: ADS_n, RD_n, WR_n, addr[11:0], and the data bus carrying the flag/high-nibble address during ADS_n.
- Latches the full 16-bit address and the cycle-status flags.
- Serves reads and writes from an internal synchronous RAM, or forwards them to a one-page memory-mapped I/O port.
- Flags halt cycles and bus protocol violations.

Parameters:
MEM_AW, 12, internal RAM address width (2^MEM_AW bytes, aliased across non-I/O space)
IO_PAGE, 8'hFF, value of latched addr[15:8] that selects the I/O port instead of RAM
WP_TOP, 16'h0400, write-protect limit (used only with the optional feature)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
ads_n  in  1  address strobe from core, active low
rd_n  in  1  read strobe from core, active low
wr_n  in  1  write strobe from core, active low
addr  in  12  core address bus
d_i  in  8  core data-out bus; during ADS_n = {H,D,I,R,addr[15:12]}, during WR_n = write data
d_o  out  8  read data to core
d_oe  out  1  d_o drive enable
io_addr  out  8  latched addr[7:0] for I/O page
io_rd  out  1  one-cycle I/O read strobe
io_wr  out  1  one-cycle I/O write strobe
io_wdata  out  8  I/O write data
io_rdata  in  8  I/O read data, held stable by peripheral while io_addr unchanged
cyc_flags  out  4  latched {H,D,I,R} of current cycle
halt_o  out  1  one-cycle pulse on a halt (H=1) address cycle
err_o  out  1  sticky protocol-error flag, cleared only by rst

Behaviour:
- Reset (rst=1 at edge): state=IDLE; d_o=0, d_oe=0, io_rd=0, io_wr=0, io_wdata=0, io_addr=0, cyc_flags=0, halt_o=0, err_o=0; latched address=0. RAM contents are not cleared.
- Reset mid-cycle returns to IDLE and drops any pending write; no io_wr is issued.
- States: IDLE, ADDR, READ, WRITE.
- Address latch, from any state except WRITE, on an edge with ads_n=0:
  - addr_q = {d_i[3:0], addr}; cyc_flags = d_i[7:4]; go to ADDR.
  - halt_o=1 for exactly the following cycle if d_i[7]=1.
  - RAM read is issued on the same edge using the incoming {d_i[3:0],addr}. Read data is valid the cycle after the latch, i.e. zero extra latency before RD_n.
- Decode: io_sel = (addr_q[15:8]==IO_PAGE). RAM index = addr_q[MEM_AW-1:0].
- ADDR:
  - rd_n=0, wr_n=1 -> READ.
  - wr_n=0, rd_n=1 -> WRITE; capture d_i.
  - rd_n=0 and wr_n=0 -> set err_o, go to IDLE.
  - ads_n=0 again -> re-latch and stay in ADDR.
- READ:
  - d_oe=1 in every READ cycle with rd_n=0.
  - d_o = io_sel ? io_rdata : RAM data.
  - io_rd=1 only in the first READ cycle, and only if io_sel.
  - rd_n=1 -> IDLE with d_oe=0 in that same cycle (combinational on rd_n).
- WRITE:
  - Capture d_i into a write register every cycle with wr_n=0.
  - On the first cycle with wr_n=1, commit: RAM write of the captured byte, or io_wr=1 with io_wdata = captured byte. Then go to IDLE.
  - ads_n=0 while wr_n=0 -> set err_o, drop the write, re-latch.
- Contention guard: d_oe=0 whenever ads_n=0 or wr_n=0, regardless of state.
- rd_n=0 or wr_n=0 in IDLE (no prior address) -> set err_o, no access, d_oe=0.
- Back-to-back: ADS in the commit cycle of a WRITE is accepted. The commit completes first, so a following read of the same address returns the new data.

Optional Feature:
SCMP_BUS_RESP_WRPROT_EN
- Defined: non-I/O writes with addr_q < WP_TOP are discarded at commit, and sticky output wp_viol_o (1 bit, reset 0) is set.
- Undefined: the wp_viol_o port does not exist and all RAM writes commit.

Test Plan:
- Reset: hold rst 2 cycles mid-WRITE (addr 16'h0123, d_i=8'h5A), release -> all outputs 0; RAM[0x123] unchanged on readback.
- RAM write/read: ADS with d_i=8'h01, addr=12'h234; WR data 8'hC3; then ADS same address and RD -> d_o=8'hC3, d_oe=1 only during rd_n=0, cyc_flags=4'h0.
- I/O read: ADS with d_i=8'h0F, addr=12'hF10; io_rdata=8'h77; RD for 2 cycles -> io_addr=8'h10, io_rd high exactly 1 cycle, d_o=8'h77, no RAM access.
- I/O write plus halt: ADS with d_i=8'h8F, addr=12'hF20; WR 8'h3C -> halt_o pulses once; io_wr pulses once after wr_n rises with io_wdata=8'h3C.
- Protocol errors: rd_n=0 and wr_n=0 together after ADS -> err_o=1, held until rst; RD without ADS in IDLE -> err_o=1, d_oe=0.
- With SCMP_BUS_RESP_WRPROT_EN: write 8'hAA to 16'h0010 -> wp_viol_o=1, readback returns the old value; write to 16'h0400 succeeds.
